// File: rtl/bus_mux_reg_if.sv
// ---------------------------------------------------------------------------
// bus_mux_reg_if
// Groups the bus-side signals of bus_mux_reg into one bundle so the mux and
// whatever drives its selects/sources can be wired with a single port.
//
// Optional feature macro: BUS_MUX_CONST_EN
//   When defined, two constant sources (0 and 1) are appended to the select
//   vector, so NSEL = NSRC+2. When undefined, NSEL = NSRC.
//
// Signals:
//   Hold      master->slave  freeze all mux state for the cycle
//   Sel       master->slave  one-hot source select, NSEL bits
//   SrcData   master->slave  flattened source data, NSRC*WIDTH bits
//   BusWires  slave->master  registered bus value
//   BusValid  slave->master  bus holds data from a legal select
//   BusSrc    slave->master  index of the source driving BusWires
//   SelErr    slave->master  high while the select is faulted
//   ErrCount  slave->master  saturating count of fault entries
//
// Modports:
//   master  drives Hold/Sel/SrcData, observes the bus outputs
//   slave   the mux itself
// ---------------------------------------------------------------------------
interface bus_mux_reg_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 10,
  parameter int ERRW  = 8
);

`ifdef BUS_MUX_CONST_EN
  localparam int NSEL = NSRC + 2;
`else
  localparam int NSEL = NSRC;
`endif
  localparam int SRCW = (NSEL > 1) ? $clog2(NSEL) : 1;

  logic                    Hold;
  logic [NSEL-1:0]         Sel;
  logic [NSRC*WIDTH-1:0]   SrcData;
  logic [WIDTH-1:0]        BusWires;
  logic                    BusValid;
  logic [SRCW-1:0]         BusSrc;
  logic                    SelErr;
  logic [ERRW-1:0]         ErrCount;

  modport master (
    output Hold, Sel, SrcData,
    input  BusWires, BusValid, BusSrc, SelErr, ErrCount
  );

  modport slave (
    input  Hold, Sel, SrcData,
    output BusWires, BusValid, BusSrc, SelErr, ErrCount
  );

endinterface

// File: rtl/bus_mux_reg.sv
// ---------------------------------------------------------------------------
// bus_mux_reg
// Registered datapath bus multiplexer. Picks one of NSRC WIDTH-bit sources
// (by default R0-R7, DIN, G) onto BusWires through a one-cycle output
// register. A small state machine checks that the select is one-hot, keeps
// the last good bus value while idle or faulted, and counts how many times
// a conflicting (multi-bit) select pushed it into the fault state.
//
// Optional feature macro: BUS_MUX_CONST_EN
//   Defined   -> Sel has NSRC+2 bits; Sel[NSRC] drives constant 0 and
//                Sel[NSRC+1] drives constant 1 (LSB set).
//   Undefined -> Sel has NSRC bits, no constant sources.
//
// Ports:
//   Clock   in   single clock, all state updates on the rising edge
//   Reset   in   synchronous active-high reset, wins over Hold
//   bus     slave modport of bus_mux_reg_if carrying Hold, Sel, SrcData
//           in and BusWires, BusValid, BusSrc, SelErr, ErrCount out
// ---------------------------------------------------------------------------
module bus_mux_reg #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 10,
  parameter int ERRW  = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  bus_mux_reg_if.slave   bus
);

`ifdef BUS_MUX_CONST_EN
  localparam int NSEL = NSRC + 2;
`else
  localparam int NSEL = NSRC;
`endif
  localparam int SRCW = (NSEL > 1) ? $clog2(NSEL) : 1;

  // One-hot state encoding, kept as plain constants for legacy tools.
  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_DRIVE = 3'b010;
  localparam logic [2:0] ST_FAULT = 3'b100;

  logic [2:0]        r_state;
  logic [WIDTH-1:0]  r_busWires;
  logic [SRCW-1:0]   r_busSrc;
  logic [ERRW-1:0]   r_errCount;

  logic              w_selZero;
  logic              w_selOne;
  logic              w_selMulti;
  logic [SRCW-1:0]   w_selIdx;
  logic [WIDTH-1:0]  w_selData;
  logic [2:0]        w_nextState;
  logic              w_load;
  logic              w_faultEntry;

  // Classify the select: clearing the lowest set bit leaves zero only when
  // exactly one bit was set, which avoids a full population count.
  assign w_selZero  = (bus.Sel == '0);
  assign w_selOne   = !w_selZero && ((bus.Sel & (bus.Sel - NSEL'(1))) == '0);
  assign w_selMulti = !w_selZero && !w_selOne;

  // Source index and data for the selected bit. The result only matters
  // when the select is a legal one-hot, so overlap between bits is harmless.
  always_comb begin
    w_selIdx  = '0;
    w_selData = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.Sel[i]) begin
        w_selIdx  = SRCW'(i);
        w_selData = bus.SrcData[i*WIDTH +: WIDTH];
      end
    end
`ifdef BUS_MUX_CONST_EN
    if (bus.Sel[NSRC]) begin
      w_selIdx  = SRCW'(NSRC);
      w_selData = '0;
    end
    if (bus.Sel[NSRC+1]) begin
      w_selIdx  = SRCW'(NSRC + 1);
      w_selData = WIDTH'(1);
    end
`endif
  end

  // Next state. Once faulted the select must drop to zero before the mux
  // will drive again, so a one-hot select alone cannot leave FAULT.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_DRIVE: begin
        if (w_selMulti)     w_nextState = ST_FAULT;
        else if (w_selOne)  w_nextState = ST_DRIVE;
        else                w_nextState = ST_IDLE;
      end
      ST_FAULT: begin
        if (w_selZero)      w_nextState = ST_IDLE;
      end
      default:              w_nextState = ST_IDLE;
    endcase
  end

  // A legal select outside FAULT loads the bus register on the same edge,
  // which gives both the IDLE->DRIVE load and bubble-free source switches.
  assign w_load       = w_selOne && (r_state != ST_FAULT);
  assign w_faultEntry = w_selMulti && (r_state != ST_FAULT);

  // State, bus register and conflict counter. Reset beats Hold; Hold
  // freezes everything including the counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_busWires <= '0;
      r_busSrc   <= '0;
      r_errCount <= '0;
    end else if (!bus.Hold) begin
      r_state <= w_nextState;
      if (w_load) begin
        r_busWires <= w_selData;
        r_busSrc   <= w_selIdx;
      end
      if (w_faultEntry && (r_errCount != {ERRW{1'b1}})) begin
        r_errCount <= r_errCount + ERRW'(1);
      end
    end
  end

  // Status flags come straight from the state register, so no input has a
  // combinational path to any output.
  assign bus.BusWires = r_busWires;
  assign bus.BusSrc   = r_busSrc;
  assign bus.BusValid = (r_state == ST_DRIVE);
  assign bus.SelErr   = (r_state == ST_FAULT);
  assign bus.ErrCount = r_errCount;

endmodule

// File: tb/tb_bus_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_bus_mux_reg
// Scoreboard bench for bus_mux_reg. The stimulus side drives inputs on the
// falling edge, advances a behavioural model of the mux and queues the
// outputs expected after the next rising edge. A separate monitor samples
// the DUT just after each rising edge and compares against the queue.
// A small counter width is used so saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_bus_mux_reg;

  localparam int WIDTH = 16;
  localparam int NSRC  = 10;
  localparam int ERRW  = 2;
`ifdef BUS_MUX_CONST_EN
  localparam int NSEL = NSRC + 2;
`else
  localparam int NSEL = NSRC;
`endif
  localparam int SRCW   = (NSEL > 1) ? $clog2(NSEL) : 1;
  localparam int CNTMAX = (1 << ERRW) - 1;

  typedef struct packed {
    logic [WIDTH-1:0] wires;
    logic             valid;
    logic [SRCW-1:0]  src;
    logic             err;
    logic [ERRW-1:0]  cnt;
  } expect_t;

  logic clock;
  logic reset;

  bus_mux_reg_if #(.WIDTH(WIDTH), .NSRC(NSRC), .ERRW(ERRW)) busIf ();

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .ERRW(ERRW)) dut (
    .Clock (clock),
    .Reset (reset),
    .bus   (busIf)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  expect_t expQ[$];
  int      errors = 0;
  int      checks = 0;

  // Behavioural model state: is the bus carrying legal data, is the select
  // faulted, what is on the bus, and how many faults have been seen.
  bit               mDriving = 0;
  bit               mFault   = 0;
  logic [WIDTH-1:0] mWires   = '0;
  int               mSrc     = 0;
  int               mCount   = 0;

  logic [NSRC*WIDTH-1:0] srcData;

  function automatic logic [NSEL-1:0] oneHot(input int idx);
    logic [NSEL-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Value presented by source idx, including the optional constants.
  function automatic logic [WIDTH-1:0] sourceValue(input int idx,
                                                   input logic [NSRC*WIDTH-1:0] data);
    if (idx < NSRC) return data[idx*WIDTH +: WIDTH];
    if (idx == NSRC) return '0;
    return WIDTH'(1);
  endfunction

  // Drive one cycle of inputs, step the model, and queue what the DUT
  // must show after the coming rising edge.
  task automatic applyStimulus(input bit rst, input bit hold,
                               input logic [NSEL-1:0] sel,
                               input logic [NSRC*WIDTH-1:0] data);
    int      ones;
    int      idx;
    expect_t e;
    @(negedge clock);
    reset         = rst;
    busIf.Hold    = hold;
    busIf.Sel     = sel;
    busIf.SrcData = data;
    ones = $countones(sel);
    idx  = 0;
    for (int i = 0; i < NSEL; i++) if (sel[i]) idx = i;
    if (rst) begin
      mDriving = 0; mFault = 0; mWires = '0; mSrc = 0; mCount = 0;
    end else if (!hold) begin
      if (mFault) begin
        if (ones == 0) mFault = 0;
      end else if (ones == 0) begin
        mDriving = 0;
      end else if (ones == 1) begin
        mDriving = 1;
        mWires   = sourceValue(idx, data);
        mSrc     = idx;
      end else begin
        mDriving = 0;
        mFault   = 1;
        if (mCount < CNTMAX) mCount++;
      end
    end
    e.wires = mWires;
    e.valid = mDriving;
    e.src   = SRCW'(mSrc);
    e.err   = mFault;
    e.cnt   = ERRW'(mCount);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    checks++;
    if (busIf.BusWires !== e.wires || busIf.BusValid !== e.valid ||
        busIf.BusSrc !== e.src || busIf.SelErr !== e.err ||
        busIf.ErrCount !== e.cnt) begin
      errors++;
      $display("[TB] FAIL busOutputs @%0t: got wires=%h valid=%b src=%0d err=%b cnt=%0d, want wires=%h valid=%b src=%0d err=%b cnt=%0d",
               $time, busIf.BusWires, busIf.BusValid, busIf.BusSrc, busIf.SelErr,
               busIf.ErrCount, e.wires, e.valid, e.src, e.err, e.cnt);
    end
  endtask

  // Monitor: every cycle the DUT presents a registered result, so pop one
  // expectation per rising edge once the stimulus side has queued any.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() != 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    logic [NSEL-1:0] sel;
    int a;
    int b;
    int r;

    reset         = 1'b1;
    busIf.Hold    = 1'b0;
    busIf.Sel     = '0;
    busIf.SrcData = '0;
    srcData       = '0;

    // Reset, then an empty select for three cycles.
    applyStimulus(1, 0, '0, srcData);
    repeat (3) applyStimulus(0, 0, '0, srcData);

    // Drive R3, then switch straight to DIN.
    srcData[3*WIDTH +: WIDTH] = 16'h1234;
    srcData[8*WIDTH +: WIDTH] = 16'hBEEF;
    applyStimulus(0, 0, oneHot(3), srcData);
    applyStimulus(0, 0, oneHot(8), srcData);

    // Conflict while driving R3, stuck select, release, drive again.
    applyStimulus(0, 0, oneHot(3), srcData);
    applyStimulus(0, 0, oneHot(1) | oneHot(2), srcData);
    applyStimulus(0, 0, oneHot(4), srcData);
    applyStimulus(0, 0, '0, srcData);
    applyStimulus(0, 0, oneHot(4), srcData);

    // Hold across a switch from R0 to R7.
    srcData[0*WIDTH +: WIDTH] = 16'h0001;
    srcData[7*WIDTH +: WIDTH] = 16'h00FF;
    applyStimulus(0, 0, oneHot(0), srcData);
    repeat (3) applyStimulus(0, 1, oneHot(7), srcData);
    applyStimulus(0, 0, oneHot(7), srcData);
    applyStimulus(0, 0, oneHot(7), srcData);

    // Repeated fault entries run the counter into saturation, then a
    // reset in the middle of FAULT.
    applyStimulus(1, 0, '0, srcData);
    repeat (5) begin
      applyStimulus(0, 0, oneHot(5) | oneHot(6), srcData);
      applyStimulus(0, 0, '0, srcData);
    end
    applyStimulus(0, 0, oneHot(0) | oneHot(9), srcData);
    applyStimulus(1, 0, oneHot(0) | oneHot(9), srcData);
    applyStimulus(0, 0, '0, srcData);

    // Reset wins over Hold.
    applyStimulus(0, 0, oneHot(2), srcData);
    applyStimulus(1, 1, oneHot(2), srcData);

`ifdef BUS_MUX_CONST_EN
    // Constant sources.
    applyStimulus(0, 0, oneHot(NSRC), srcData);
    applyStimulus(0, 0, oneHot(NSRC + 1), srcData);
`endif

    // Randomized traffic with fresh source data every cycle.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSRC; i++) srcData[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      r = $urandom_range(0, 99);
      if (r < 35) begin
        sel = '0;
      end else if (r < 80) begin
        sel = oneHot($urandom_range(0, NSEL - 1));
      end else begin
        a = $urandom_range(0, NSEL - 1);
        b = (a + $urandom_range(1, NSEL - 1)) % NSEL;
        sel = oneHot(a) | oneHot(b) | (NSEL'($urandom) & NSEL'($urandom));
      end
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, sel, srcData);
    end

    // Let the monitor drain the queue, bounded in case it never does.
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clock);
    #2;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainQueue: got %0d pending, want 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
